// File: rtl/pipe_seq.sv
// Pipeline sequencer: fill, run, stall, mispredict flush and halt control with a stall watchdog.
// Optional performance counters (StallCnt/FlushCnt) are built only when PIPE_SEQ_PERF_EN is defined.
module pipe_seq #(
  parameter logic [15:0] HALT_WORD   = 16'hFFFF,
  parameter int          FILL_CYCLES = 3,
  parameter int          WDOG_LIMIT  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallReq,
  input  logic        MP,
  input  logic [15:0] IFID,
  input  logic        Resume,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic [2:0]  State,
  output logic        Deadlock,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  // Handshake note: there is no valid/ready pair here; every input is sampled
  // combinationally in the cycle it is presented and acts with zero latency.
  typedef enum logic [2:0] {
    FILL  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] fill_q;
  logic [7:0] wd_q;
  logic       dl_q;
  logic       stall_path;
  logic       wd_hit;
  logic       in_fill;

  assign in_fill = !(state_q inside {RUN, STALL, FLUSH, HALT});

  always_comb begin
    state_d    = FILL;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b1;
    EXMEMFlush = 1'b1;
    stall_path = 1'b0;
    case (state_q)
      RUN, STALL: begin
        EXMEMFlush = 1'b0;
        if (MP) begin
          IFIDFlush = 1'b1;
          state_d   = FLUSH;
        end else if (StallReq) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          stall_path = 1'b1;
          state_d    = STALL;
        end else if (IFID == HALT_WORD) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          state_d   = HALT;
        end else begin
          IDEXFlush = 1'b0;
          state_d   = RUN;
        end
      end
      FLUSH: begin
        IFIDFlush  = 1'b1;
        EXMEMFlush = 1'b0;
        state_d    = RUN;
      end
      HALT: begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        EXMEMFlush = 1'b0;
        state_d    = Resume ? RUN : HALT;
      end
      default: begin
        // FILL and the unused encodings 5..7 all behave as FILL
        state_d = (fill_q == 3'(FILL_CYCLES - 1)) ? RUN : FILL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      fill_q  <= 3'd0;
      wd_q    <= 8'd0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= in_fill ? fill_q + 3'd1 : 3'd0;
      if (stall_path) wd_q <= (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
      else            wd_q <= 8'd0;
      if (wd_hit) dl_q <= 1'b1;
    end
  end

  // Deadlock asserts in the very stall cycle that brings the run to the limit.
  assign wd_hit   = stall_path && ({1'b0, wd_q} + 9'd1 >= 9'(WDOG_LIMIT));
  assign Deadlock = dl_q | wd_hit;
  assign State    = state_q;

`ifdef PIPE_SEQ_PERF_EN
  logic        flush_path;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  assign flush_path = (state_q == RUN || state_q == STALL) && MP;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_path && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_path && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = 16'd0;
  assign FlushCnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_seq.sv
// Bench for pipe_seq: table of per-cycle vectors through an expected-value queue,
// plus hand-written reset-state and asynchronous-reset-mid-FLUSH sequences.
module tb_pipe_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        StallReq, MP, Resume;
  logic [15:0] IFID;
  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Deadlock;
  logic [2:0]  State;
  logic [15:0] StallCnt, FlushCnt;

  pipe_seq dut (
    .clock(clock), .reset(reset), .StallReq(StallReq), .MP(MP), .IFID(IFID),
    .Resume(Resume), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush), .State(State), .Deadlock(Deadlock),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // decode = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush}
  localparam logic [4:0] D_FILL  = 5'b11011;
  localparam logic [4:0] D_RUN   = 5'b11000;
  localparam logic [4:0] D_STALL = 5'b00010;
  localparam logic [4:0] D_MP    = 5'b11110;
  localparam logic [4:0] D_HALT  = 5'b00010;

  typedef struct {
    logic        stall;
    logic        mp;
    logic [15:0] ifid;
    logic        resume;
    logic [40:0] exp;   // {State, decode, Deadlock, StallCnt, FlushCnt}
  } vec_t;

  vec_t        vecs[$];
  logic [40:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [40:0] pack_exp(input logic [2:0] st, input logic [4:0] dec,
                                           input logic dl, input int sc, input int fc);
    logic [15:0] s, f;
`ifdef PIPE_SEQ_PERF_EN
    s = 16'(sc);
    f = 16'(fc);
`else
    s = 16'd0 + 16'(sc * 0);
    f = 16'd0 + 16'(fc * 0);
`endif
    return {st, dec, dl, s, f};
  endfunction

  function automatic logic [40:0] sample();
    return {State, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Deadlock, StallCnt, FlushCnt};
  endfunction

  task automatic add(input logic s, input logic m, input logic [15:0] ifid, input logic r,
                     input logic [2:0] st, input logic [4:0] dec, input logic dl,
                     input int sc, input int fc);
    vec_t v;
    v.stall = s; v.mp = m; v.ifid = ifid; v.resume = r;
    v.exp = pack_exp(st, dec, dl, sc, fc);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [40:0] got, input logic [40:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s idx %0d got state=%0d dec=%b dl=%b sc=%0d fc=%0d exp state=%0d dec=%b dl=%b sc=%0d fc=%0d",
               name, idx, got[40:38], got[37:33], got[32], got[31:16], got[15:0],
               exp[40:38], exp[37:33], exp[32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic drive(input logic s, input logic m, input logic [15:0] ifid, input logic r);
    StallReq = s; MP = m; IFID = ifid; Resume = r;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0);

    // fill-phase: stimulus that must be ignored
    add(1, 1, 16'h0000, 0, 3'd0, D_FILL, 0, 0, 0);
    add(0, 0, 16'hFFFF, 0, 3'd0, D_FILL, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 3'd0, D_FILL, 0, 0, 0);
    add(0, 0, 16'h1234, 0, 3'd1, D_RUN,  0, 0, 0);
    // four-cycle stall
    add(1, 0, 16'h0000, 0, 3'd1, D_STALL, 0, 0, 0);
    for (int j = 1; j <= 3; j++) add(1, 0, 16'h0000, 0, 3'd2, D_STALL, 0, j, 0);
    add(0, 0, 16'h0000, 0, 3'd2, D_RUN, 0, 4, 0);
    add(0, 0, 16'h0000, 0, 3'd1, D_RUN, 0, 4, 0);
    // mispredict while stalled, FLUSH ignores inputs
    add(1, 0, 16'h0000, 0, 3'd1, D_STALL, 0, 4, 0);
    add(1, 1, 16'h0000, 0, 3'd2, D_MP,    0, 5, 0);
    add(1, 1, 16'h0000, 0, 3'd3, D_MP,    0, 5, 1);
    add(0, 0, 16'h0000, 0, 3'd1, D_RUN,   0, 5, 1);
    add(0, 1, 16'h0000, 0, 3'd1, D_MP,    0, 5, 1);
    add(0, 0, 16'h0000, 0, 3'd3, D_MP,    0, 5, 2);
    // halt, ignore MP/StallReq, resume
    add(0, 0, 16'hFFFF, 0, 3'd1, D_HALT, 0, 5, 2);
    add(1, 1, 16'hFFFF, 0, 3'd4, D_HALT, 0, 5, 2);
    add(0, 0, 16'h0000, 0, 3'd4, D_HALT, 0, 5, 2);
    add(0, 0, 16'h0000, 1, 3'd4, D_HALT, 0, 5, 2);
    add(0, 0, 16'h0000, 0, 3'd1, D_RUN,  0, 5, 2);
    // 15-cycle stall: watchdog fires on the 15th stall cycle and sticks
    add(1, 0, 16'h0000, 0, 3'd1, D_STALL, 0, 5, 2);
    for (int k = 2; k <= 15; k++) add(1, 0, 16'h0000, 0, 3'd2, D_STALL, (k == 15), 4 + k, 2);
    add(0, 0, 16'h0000, 0, 3'd2, D_RUN, 1, 20, 2);
    add(0, 0, 16'h0000, 0, 3'd1, D_RUN, 1, 20, 2);
    add(0, 1, 16'h0000, 0, 3'd1, D_MP,  1, 20, 2);

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    drive(1'b1, 1'b1, 16'hFFFF, 1'b0);
    #2;
    check("reset_hold", 0, sample(), pack_exp(3'd0, D_FILL, 0, 0, 0));
    drive(1'b0, 1'b0, 16'h0000, 1'b0);

    @(negedge clock);
    reset = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].mp, vecs[i].ifid, vecs[i].resume);
      exp_q.push_back(vecs[i].exp);
      #2;
      check("vector", i, sample(), exp_q.pop_front());
      @(negedge clock);
    end

    // now inside FLUSH: assert reset between edges, response must be immediate
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    #2;
    check("in_flush", 0, sample(), pack_exp(3'd3, D_MP, 1, 20, 3));
    #1 reset = 1'b0;
    #1;
    check("async_reset", 0, sample(), pack_exp(3'd0, D_FILL, 0, 0, 0));
    @(negedge clock);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back((c < 3) ? pack_exp(3'd0, D_FILL, 0, 0, 0) : pack_exp(3'd1, D_RUN, 0, 0, 0));
      #2;
      check("refill", c, sample(), exp_q.pop_front());
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_seq.md
PIPE_SEQ -- requirements
Module: pipe_seq

Interface
REQ-001 SHALL have parameter HALT_WORD, default 16'hFFFF, the IFID instruction encoding that halts the pipeline.
REQ-002 SHALL have parameter FILL_CYCLES, default 3, the number of post-reset pipeline-fill cycles (range 1..7).
REQ-003 SHALL have parameter WDOG_LIMIT, default 15, the consecutive-stall count that raises Deadlock (range 1..255).
REQ-004 SHALL have ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallReq  in  1  data-hazard stall request from the hazard controller.
- MP  in  1  branch misprediction, one cycle per event.
- IFID  in  16  instruction held in the IF/ID register.
- Resume  in  1  leave HALT.
- PCWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IFIDFlush  out  1  zero the IF/ID register.
- IDEXFlush  out  1  insert a bubble into ID/EX.
- EXMEMFlush  out  1  insert a bubble into EX/MEM.
- State  out  3  current state encoding.
- Deadlock  out  1  sticky stall-watchdog flag.
- StallCnt  out  16  stall-cycle counter.
- FlushCnt  out  16  mispredict-flush counter.

Function
REQ-005 SHALL implement a registered FSM with states FILL=0, RUN=1, STALL=2, FLUSH=3, HALT=4; encodings 5..7 SHALL be treated as FILL.
REQ-006 Outputs SHALL be a combinational decode of the current state and current inputs. A change on StallReq or MP SHALL act in the same cycle, with zero latency.
REQ-007 FILL: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=1, EXMEMFlush=1. A 3-bit counter SHALL count fill cycles. After FILL_CYCLES cycles the FSM SHALL go to RUN. StallReq, MP and HALT_WORD SHALL be ignored in FILL.
REQ-008 In RUN and STALL, priority SHALL be MP > StallReq > HALT_WORD match > normal.
REQ-009 MP=1 in RUN or STALL: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=0; next state FLUSH.
REQ-010 StallReq=1 (MP=0): PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXFlush=1, EXMEMFlush=0; next state STALL.
REQ-011 IFID==HALT_WORD (MP=0, StallReq=0): PCWrite=0, IFIDWrite=0, IDEXFlush=1, other flushes 0; next state HALT.
REQ-012 Normal (none of the above): PCWrite=1, IFIDWrite=1, all flushes 0; next state RUN.
REQ-013 FLUSH SHALL last exactly one cycle: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=0; next state RUN. MP and StallReq SHALL be ignored in FLUSH.
REQ-014 HALT: PCWrite=0, IFIDWrite=0, IDEXFlush=1, other flushes 0; MP and StallReq ignored. Resume=1 SHALL give next state RUN.
REQ-015 An 8-bit consecutive-stall counter SHALL increment in each STALL-path cycle (REQ-010 output) and clear on any other cycle. When it reaches WDOG_LIMIT, Deadlock SHALL set and hold until reset. The counter SHALL saturate at 255.
REQ-016 The watchdog SHALL NOT force an exit from STALL.

Reset
REQ-017 reset=0 SHALL immediately, asynchronously, force: State=FILL; fill counter=0; watchdog counter=0; Deadlock=0; StallCnt=0; FlushCnt=0.
REQ-018 While reset=0, outputs SHALL equal the FILL decode (REQ-007). Reset asserted mid-STALL, FLUSH or HALT SHALL abort that state with no further effect.

Configuration
REQ-019 When macro PIPE_SEQ_PERF_EN is defined:
- StallCnt SHALL increment on each STALL-path cycle.
- FlushCnt SHALL increment on each REQ-009 cycle.
- Both SHALL saturate at 16'hFFFF.
REQ-020 When PIPE_SEQ_PERF_EN is undefined, StallCnt and FlushCnt SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-021 Reset release, all inputs 0 -> 3 cycles with IDEXFlush=EXMEMFlush=1 and State=0, then State=1 and PCWrite=1.
REQ-022 In RUN, StallReq=1 for 4 cycles -> PCWrite=IFIDWrite=0 and IDEXFlush=1 for those 4 cycles; StallCnt +4 (PERF_EN); State=1 on the cycle after StallReq drops.
REQ-023 In STALL, MP=1 with StallReq=1 -> same cycle: IFIDFlush=1, PCWrite=1; next cycle State=3; following cycle State=1; FlushCnt=1.
REQ-024 StallReq held 15 cycles -> Deadlock=1 on the 15th stall cycle. Deadlock stays 1 after StallReq drops, until reset=0.
REQ-025 IFID=16'hFFFF in RUN -> State=4, PCWrite=0. MP=1 in HALT -> no effect. Resume=1 -> State=1 next cycle.
REQ-026 reset=0 pulsed mid-FLUSH between clock edges -> State=0 and IDEXFlush=1 without waiting for a clock edge; counters read 0.
